// File: rtl/bf16_add_align.sv
// bfloat16 adder front end: unpack, classify, order by magnitude and align the smaller operand.
// Define BF16_ADD_ALIGN_FTZ_EN to flush denormal inputs to signed zero before classification.
`timescale 1ns/1ps
module bf16_add_align #(
  parameter int sig_width = 7,
  parameter int exp_width = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [exp_width+sig_width:0]   a,
  input  logic [exp_width+sig_width:0]   b,
  input  logic [2:0]                     rnd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           big_sign,
  output logic                           small_sign,
  output logic [exp_width-1:0]           big_exp,
  output logic [sig_width:0]             big_mant,
  output logic [sig_width+3:0]           small_mant,
  output logic                           eff_sub,
  output logic [2:0]                     rnd_out,
  output logic                           special,
  output logic [exp_width+sig_width:0]   z_special,
  output logic [7:0]                     status
);

  localparam int fw = sig_width;
  localparam int ew = exp_width;
  localparam int mw = sig_width + 4;
  localparam logic [ew-1:0] emax = '1;

  logic s1_valid, s2_load, s1_adv;

  // in_ready never depends on in_valid, only on registered state and out_ready
  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  logic          sa, sb;
  logic [ew-1:0] ea, eb, xa, xb, d;
  logic [fw-1:0] fa, fb;
  logic          nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, swap;
  logic          c_big_sign, c_small_sign;
  logic [ew-1:0] c_big_exp;
  logic [fw:0]   c_big_mant, c_small_sig;

  always_comb begin
    sa = a[ew+fw];
    sb = b[ew+fw];
    ea = a[ew+fw-1:fw];
    eb = b[ew+fw-1:fw];
    fa = a[fw-1:0];
    fb = b[fw-1:0];
`ifdef BF16_ADD_ALIGN_FTZ_EN
    if (ea == '0) fa = '0;
    if (eb == '0) fb = '0;
`endif
    nan_a  = (ea == emax) && (fa != '0);
    nan_b  = (eb == emax) && (fb != '0);
    inf_a  = (ea == emax) && (fa == '0);
    inf_b  = (eb == emax) && (fb == '0);
    zero_a = (ea == '0) && (fa == '0);
    zero_b = (eb == '0) && (fb == '0);
    // denormals share the minimum normal exponent but lose the hidden bit
    xa = (ea == '0) ? ew'(1) : ea;
    xb = (eb == '0) ? ew'(1) : eb;
    swap = {eb, fb} > {ea, fa};
    if (swap) begin
      c_big_sign   = sb;
      c_small_sign = sa;
      c_big_exp    = xb;
      c_big_mant   = {(eb != '0), fb};
      c_small_sig  = {(ea != '0), fa};
      d            = xb - xa;
    end else begin
      c_big_sign   = sa;
      c_small_sign = sb;
      c_big_exp    = xa;
      c_big_mant   = {(ea != '0), fa};
      c_small_sig  = {(eb != '0), fb};
      d            = xa - xb;
    end
  end

  logic          s1_big_sign, s1_small_sign, s1_sa, s1_sb;
  logic          s1_nan, s1_inf_a, s1_inf_b, s1_zero;
  logic [ew-1:0] s1_big_exp, s1_d;
  logic [fw:0]   s1_big_mant, s1_small_sig;
  logic [2:0]    s1_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_big_sign   <= 1'b0;
      s1_small_sign <= 1'b0;
      s1_sa         <= 1'b0;
      s1_sb         <= 1'b0;
      s1_nan        <= 1'b0;
      s1_inf_a      <= 1'b0;
      s1_inf_b      <= 1'b0;
      s1_zero       <= 1'b0;
      s1_big_exp    <= '0;
      s1_d          <= '0;
      s1_big_mant   <= '0;
      s1_small_sig  <= '0;
      s1_rnd        <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_big_sign   <= c_big_sign;
        s1_small_sign <= c_small_sign;
        s1_sa         <= sa;
        s1_sb         <= sb;
        s1_nan        <= nan_a || nan_b;
        s1_inf_a      <= inf_a;
        s1_inf_b      <= inf_b;
        s1_zero       <= zero_a && zero_b;
        s1_big_exp    <= c_big_exp;
        s1_d          <= d;
        s1_big_mant   <= c_big_mant;
        s1_small_sig  <= c_small_sig;
        s1_rnd        <= rnd;
      end
    end
  end

  logic [2*mw-1:0]     wide;
  logic [mw-1:0]       aligned;
  logic                sticky;
  logic                c_special;
  logic [ew+fw:0]      c_z;
  logic [7:0]          c_status;

  // lower half of the wide shift catches every bit pushed past the sticky position
  always_comb begin
    wide   = {s1_small_sig, 3'b000, {mw{1'b0}}} >> s1_d;
    sticky = |wide[mw-1:0];
    if (s1_d >= ew'(mw))
      aligned = {{(mw-1){1'b0}}, |s1_small_sig};
    else
      aligned = wide[2*mw-1:mw] | {{(mw-1){1'b0}}, sticky};
  end

  always_comb begin
    c_special = 1'b0;
    c_z       = '0;
    c_status  = 8'h00;
    if (s1_nan || (s1_inf_a && s1_inf_b && (s1_sa != s1_sb))) begin
      c_special = 1'b1;
      c_z       = {1'b0, emax, 1'b1, {(fw-1){1'b0}}};
      c_status  = 8'h04;
    end else if (s1_inf_a || s1_inf_b) begin
      c_special = 1'b1;
      c_z       = {(s1_inf_a ? s1_sa : s1_sb), emax, {fw{1'b0}}};
      c_status  = 8'h02;
    end else if (s1_zero) begin
      c_special = 1'b1;
      c_z       = {((s1_rnd == 3'd2) ? (s1_sa | s1_sb) : (s1_sa & s1_sb)), {(ew+fw){1'b0}}};
      c_status  = 8'h01;
    end
  end

  // output registers only move when S2 may load, so a stalled result stays bit-stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      big_exp    <= '0;
      big_mant   <= '0;
      small_mant <= '0;
      eff_sub    <= 1'b0;
      rnd_out    <= '0;
      special    <= 1'b0;
      z_special  <= '0;
      status     <= 8'h00;
    end else begin
      if (s2_load) out_valid <= s1_valid;
      if (s1_adv) begin
        big_sign   <= s1_big_sign;
        small_sign <= s1_small_sign;
        big_exp    <= s1_big_exp;
        big_mant   <= s1_big_mant;
        small_mant <= aligned;
        eff_sub    <= s1_big_sign ^ s1_small_sign;
        rnd_out    <= s1_rnd;
        special    <= c_special;
        z_special  <= c_z;
        status     <= c_status;
      end
    end
  end

endmodule

// File: doc/bf16_add_align.md
# bf16_add_align

Pipelined operand-preparation stage that sits directly upstream of the bfloat16 adder datapath. It accepts two bfloat16 operands plus a rounding mode over a valid/ready handshake. It unpacks and classifies both operands, orders them by magnitude, and aligns the smaller significand with guard/round/sticky bits. It also resolves special-value results (NaN, infinity, both-zero) so the downstream add/normalize stage only handles finite arithmetic.

## Interface
- `sig_width`, 7, stored fraction bits
- `exp_width`, 8, exponent bits
- `clk` input 1 — single clock, all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — operand pair valid
- `in_ready` output 1 — stage can accept operands
- `a`, `b` input exp_width+sig_width+1 — bfloat16 operands
- `rnd` input 3 — rounding mode, passed through (0 = RNE, 2 = toward −inf)
- `out_valid` output 1 — result fields valid
- `out_ready` input 1 — downstream accepts
- `big_sign`, `small_sign` output 1 — signs of larger-/smaller-magnitude operand
- `big_exp` output exp_width — effective exponent of larger operand
- `big_mant` output sig_width+1 — larger significand with hidden bit
- `small_mant` output sig_width+4 — aligned smaller significand, {hidden, frac, G, R, S}
- `eff_sub` output 1 — `big_sign ^ small_sign`
- `rnd_out` output 3 — registered `rnd`
- `special` output 1 — result fully determined; use `z_special`
- `z_special` output exp_width+sig_width+1 — special result
- `status` output 8 — bit0 zero, bit1 infinity, bit2 invalid, others 0

## Operation
- Unpack: exponent 0 is a denormal. Effective exponent = 1, hidden bit = 0; otherwise hidden bit = 1.
- Ordering: compare {exp, frac} unsigned. The strictly larger operand is "big". On a tie, `a` is big.
- d = big effective exp − small effective exp, unsigned, exp_width bits.
- Alignment: take {hidden, frac, 3'b000} and shift right by d. S = OR of all shifted-out bits, ORed into the LSB.
- If d ≥ sig_width+4: `small_mant` = {0…0, |{hidden, frac}}.
- Special resolution, in priority order:
  - Either input NaN → 0x7FC0, status bit2.
  - Inf + inf of opposite sign → 0x7FC0, status bit2.
  - Any inf → that inf, status bit1.
  - Both zero → ±0, status bit0. Sign is `sa & sb`, or `sa | sb` when rnd = 2.
- When `special` = 0: `z_special` = 0 and `status` = 0.
- Datapath fields are always computed, even when `special` = 1.

## Timing
- Two-stage pipeline, S1 and S2, each with its own valid register.
  - S1 registers: unpack, classification, swap, and d.
  - S2 registers: shift, sticky, special result, and status.
- Latency: 2 cycles from input handshake to `out_valid`. Throughput is 1 per cycle when `out_ready` = 1.
- Advance rules:
  - S2 loads when S2 is empty or `out_ready` = 1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - `in_ready` = !s1_valid | s1_advance. It is combinational from `out_ready` and registers, not from `in_valid`.
- While `out_valid` && !`out_ready`, all outputs are held bit-stable.
- With the pipeline full and stalled, `in_ready` = 0.
- Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
- Reset, asynchronous and active-low, applies at any time:
  - Both valid registers and all output data registers clear to 0.
  - `out_valid` = 0 and `in_ready` = 1 after release.
  - In-flight operands are discarded.

## Configuration
- `BF16_ADD_ALIGN_FTZ_EN`
  - Defined: denormal inputs are replaced by sign-preserving zero before classification. Both-zero special handling then applies.
  - Undefined: denormals are handled gradually as described above.
- Both builds have identical ports and latency.

## Test plan
- 1.0 + 1.0 (`a` = 0x3F80, `b` = 0x3F80):
  - `big_exp` = 0x7F, `big_mant` = 0x80, `small_mant` = 0x400, `eff_sub` = 0, `special` = 0.
  - `out_valid` asserts exactly 2 cycles after the handshake.
- 1.0 + 2.0 (`a` = 0x3F80, `b` = 0x4000):
  - Swap occurs: `big_exp` = 0x80, `small_mant` = 0x200.
- Large gap (`a` = 0x4B00, `b` = 0xBF81):
  - d = 23: `small_mant` = 0x001, `eff_sub` = 1, `small_sign` = 1.
- Specials:
  - 0x7F80 + 0xFF80 → `special` = 1, `z_special` = 0x7FC0, `status` = 0x04.
  - 0x8000 + 0x8000 with rnd = 0 → `z_special` = 0x8000, `status` = 0x01.
- Backpressure: stream 4 pairs with `out_ready` = 0 for 5 cycles.
  - `in_ready` drops after 2 are accepted and outputs hold stable.
  - After release, all 4 pairs emerge in order with no loss or duplication.
- Reset mid-stream: assert `rst_n` low with 2 operands in flight.
  - `out_valid` is 0 immediately.
  - After release, no stale result appears.
  - Denormal 0x0001 + 0x0001 yields `big_exp` = 1, `big_mant` = 0x01 without FTZ, and `special` = 1, `z_special` = 0x0000 with FTZ.
